// File: rtl/ls_io_responder_pkg.sv
// Shared types and defaults for the load/store IO responder.
// Address range constants mirror the IO/bus window of the core.
package ls_io_responder_pkg;

   localparam logic [31:0] IO_BASE_ADDR = 32'h6000_0000;
   localparam logic [31:0] IO_ERR_DATA  = 32'hDEAD_BEEF;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        w_nrr;
      logic [3:0]  wstrb;
   } ls_req_t;

endpackage

// File: rtl/ls_io_responder_if.sv
// Simple memory/IO port between the load/store unit and its target.
// No back-pressure: one request per addr_en cycle.
interface ls_io_responder_if;

   logic        addr_en;
   logic [31:0] s_axi_addr;
   logic [31:0] s_axi_wdata;
   logic        w_nrr;
   logic [3:0]  wstrb;
   logic [31:0] s_axi_rdata;
   logic        s_axi_rvalid;

   modport master (
      output addr_en, s_axi_addr, s_axi_wdata, w_nrr, wstrb,
      input  s_axi_rdata, s_axi_rvalid
   );

   modport slave (
      input  addr_en, s_axi_addr, s_axi_wdata, w_nrr, wstrb,
      output s_axi_rdata, s_axi_rvalid
   );

endinterface

// File: rtl/ls_io_responder_ram.sv
// Word array with per-byte write enables and a registered read port.
// Contents are not reset; only the read register is.
module byte_en_ram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    we_i,
   input  logic          re_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ls_io_responder.sv
// Slave responder for the LSU memory/IO port: byte-strobe writes,
// fixed-latency in-order reads, sticky range/overflow status.
module ls_io_responder
   import ls_io_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = IO_BASE_ADDR,
   parameter int          DEPTH_WORDS  = 1024,
   parameter int          READ_LATENCY = 1,
   parameter logic [31:0] ERR_DATA     = IO_ERR_DATA
) (
   input  logic             clk,
   input  logic             rst,
   ls_io_responder_if.slave bus,
   input  logic             err_clr,
   output logic             err_range,
   output logic             err_overflow,
   output logic             idle
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(READ_LATENCY + 1);
   localparam logic [32:0] LO = {1'b0, BASE_ADDR};
   localparam logic [32:0] HI = LO + 33'(4 * DEPTH_WORDS);

   ls_req_t           req;
   logic [32:0]       addr33;
   logic              in_range;
   logic [31:0]       off;
   logic [AW-1:0]     idx;
   logic              rd_req;
   logic              wr_ok;
   logic [3:0]        we;
   logic [31:0]       ram_rdata;
   logic [31:0]       d0;
   logic              oor_q;
   logic [READ_LATENCY-1:0] v_q;
   logic              rvalid;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ovf_set;
   logic              err_range_q, err_range_d;
   logic              err_ovf_q, err_ovf_d;

   assign req = '{
      addr:  bus.s_axi_addr,
      wdata: bus.s_axi_wdata,
      w_nrr: bus.w_nrr,
      wstrb: bus.wstrb
   };

   // 33-bit compare so the top word of the address space cannot wrap
   assign addr33   = {1'b0, req.addr};
   assign in_range = (addr33 >= LO) && (addr33 < HI);
   assign off      = req.addr - BASE_ADDR;
   assign idx      = off[AW+1:2];

   assign rd_req = bus.addr_en & ~req.w_nrr;
   assign wr_ok  = bus.addr_en & req.w_nrr & in_range & ~rst;
   assign we     = wr_ok ? req.wstrb : 4'b0000;

   byte_en_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we_i    (we),
      .re_i    (rd_req & in_range),
      .addr_i  (idx),
      .wdata_i (req.wdata),
      .rdata_o (ram_rdata)
   );

   assign d0     = oor_q ? ERR_DATA : ram_rdata;
   assign rvalid = v_q[READ_LATENCY-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         oor_q <= 1'b0;
         v_q   <= '0;
      end else begin
         if (rd_req) oor_q <= ~in_range;
         v_q[0] <= rd_req;
         for (int i = 1; i < READ_LATENCY; i++) begin
            v_q[i] <= v_q[i-1];
         end
      end
   end

   // Data stages only load behind a valid, so rdata holds between pulses
   if (READ_LATENCY == 1) begin : g_l1
      assign bus.s_axi_rdata = d0;
   end else begin : g_pipe
      logic [31:0] dq [1:READ_LATENCY-1];
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int i = 1; i < READ_LATENCY; i++) dq[i] <= '0;
         end else begin
            if (v_q[0]) dq[1] <= d0;
            for (int i = 2; i < READ_LATENCY; i++) begin
               if (v_q[i-1]) dq[i] <= dq[i-1];
            end
         end
      end
      assign bus.s_axi_rdata = dq[READ_LATENCY-1];
   end

   always_comb begin
      cnt_d   = cnt_q;
      ovf_set = 1'b0;
      unique case ({rd_req, rvalid})
         2'b10: begin
            if (cnt_q == CW'(READ_LATENCY)) ovf_set = 1'b1;
            else cnt_d = cnt_q + 1'b1;
         end
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   assign err_range_d = (bus.addr_en & ~in_range)
                      | (err_range_q & ~err_clr);
   assign err_ovf_d   = ovf_set | (err_ovf_q & ~err_clr);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         err_range_q <= 1'b0;
         err_ovf_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         err_range_q <= err_range_d;
         err_ovf_q   <= err_ovf_d;
      end
   end

   assign bus.s_axi_rvalid = rvalid;
   assign err_range        = err_range_q;
   assign err_overflow     = err_ovf_q;
   assign idle             = (cnt_q == '0);

endmodule

// File: tb/tb_ls_io_responder.sv
// Directed bench: three responders (latency 1, 3, 2) share one request
// stream; each has its own expected-read queue and return monitor.
module tb_ls_io_responder;

   localparam logic [31:0] BASE = 32'h6000_0000;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
   localparam int          NW   = 1024;
   localparam int          LAT [3] = '{1, 3, 2};

   typedef struct {
      logic [31:0] d;
      int          c;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        addr_en = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        w_nrr = 1'b0;
   logic [3:0]  wstrb = '0;
   logic        err_clr = 1'b0;

   logic        rv_a [3];
   logic [31:0] rd_a [3];
   logic        er_a [3];
   logic        eo_a [3];
   logic        id_a [3];

   int          cyc = 0;
   int          n_assert = 0;
   int          n_fail = 0;
   exp_t        q [3][$];
   logic [31:0] mdl [NW];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   for (genvar k = 0; k < 3; k++) begin : g_dut
      ls_io_responder_if bus_if ();
      assign bus_if.addr_en     = addr_en;
      assign bus_if.s_axi_addr  = addr;
      assign bus_if.s_axi_wdata = wdata;
      assign bus_if.w_nrr       = w_nrr;
      assign bus_if.wstrb       = wstrb;
      assign rv_a[k] = bus_if.s_axi_rvalid;
      assign rd_a[k] = bus_if.s_axi_rdata;

      ls_io_responder #(
         .BASE_ADDR    (BASE),
         .DEPTH_WORDS  (NW),
         .READ_LATENCY (LAT[k]),
         .ERR_DATA     (ERRD)
      ) dut (
         .clk          (clk),
         .rst          (rst),
         .bus          (bus_if.slave),
         .err_clr      (err_clr),
         .err_range    (er_a[k]),
         .err_overflow (eo_a[k]),
         .idle         (id_a[k])
      );

      always @(negedge clk) begin
         exp_t e;
         if (rv_a[k]) begin
            chk($sformatf("L%0d rvalid_expected", LAT[k]),
                32'(q[k].size() != 0), 32'd1);
            if (q[k].size() != 0) begin
               e = q[k].pop_front();
               chk($sformatf("L%0d rdata", LAT[k]), rd_a[k], e.d);
               chk($sformatf("L%0d rvalid_cycle", LAT[k]), cyc, e.c);
            end
         end
      end
   end

   function automatic bit in_rng(logic [31:0] a);
      logic [31:0] o;
      o = a - BASE;
      return o < 32'(4 * NW);
   endfunction

   task automatic wr(logic [31:0] a, logic [31:0] d, logic [3:0] s);
      logic [31:0] o;
      @(negedge clk);
      addr_en = 1'b1; w_nrr = 1'b1; addr = a; wdata = d; wstrb = s;
      err_clr = 1'b0;
      if (in_rng(a)) begin
         o = (a - BASE) >> 2;
         for (int i = 0; i < 4; i++)
            if (s[i]) mdl[o][8*i +: 8] = d[8*i +: 8];
      end
   endtask

   task automatic rd(logic [31:0] a, logic [31:0] exp, logic [2:0] m);
      exp_t e;
      @(negedge clk);
      addr_en = 1'b1; w_nrr = 1'b0; addr = a; wdata = '0; wstrb = '0;
      err_clr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (m[k]) begin
            e.d = exp;
            e.c = cyc + LAT[k];
            q[k].push_back(e);
         end
      end
   endtask

   task automatic nop(int n);
      repeat (n) begin
         @(negedge clk);
         addr_en = 1'b0; w_nrr = 1'b0; wstrb = '0; err_clr = 1'b0;
      end
   endtask

   task automatic chk_err(string tag, logic exp);
      for (int k = 0; k < 3; k++)
         chk($sformatf("L%0d %s", LAT[k], tag), 32'(er_a[k]), 32'(exp));
   endtask

   initial begin
      for (int i = 0; i < NW; i++) mdl[i] = 'x;

      // reset and quiet idle
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("L%0d rst_rvalid", LAT[k]), 32'(rv_a[k]), 32'd0);
            chk($sformatf("L%0d rst_erange", LAT[k]), 32'(er_a[k]), 32'd0);
            chk($sformatf("L%0d rst_eovf", LAT[k]), 32'(eo_a[k]), 32'd0);
            chk($sformatf("L%0d rst_idle", LAT[k]), 32'(id_a[k]), 32'd1);
         end
      end

      // byte-strobe merge
      wr(BASE + 8, 32'h1122_3344, 4'hF);
      wr(BASE + 8, 32'hAA00_0000, 4'b1000);
      rd(BASE + 8, 32'hAA22_3344, 3'b111);
      nop(6);

      // back-to-back reads of words 0..3
      for (int i = 0; i < 4; i++) wr(BASE + 32'(4 * i), 32'(i), 4'hF);
      for (int i = 0; i < 4; i++) begin
         rd(BASE + 32'(4 * i), 32'(i), 3'b111);
         if (i > 0) chk("L3 idle_busy", 32'(id_a[1]), 32'd0);
      end
      for (int i = 0; i < 3; i++) begin
         nop(1);
         chk("L3 idle_drain", 32'(id_a[1]), 32'd0);
      end
      nop(1);
      chk("L3 idle_done", 32'(id_a[1]), 32'd1);
      nop(4);

      // zero strobe is a no-op
      wr(BASE, 32'hFFFF_FFFF, 4'b0000);
      rd(BASE, mdl[0], 3'b111);
      nop(5);

      // last in-range word
      wr(BASE + 32'(4 * (NW - 1)), 32'h0BAD_F00D, 4'hF);
      rd(BASE + 32'(4 * (NW - 1)), 32'h0BAD_F00D, 3'b111);
      nop(1);
      chk_err("erange_last_word", 1'b0);
      nop(4);

      // first out-of-range word, sticky flag, clear, clear vs new error
      rd(BASE + 32'(4 * NW), ERRD, 3'b111);
      nop(1);
      chk_err("erange_set", 1'b1);
      nop(4);
      chk_err("erange_sticky", 1'b1);
      @(negedge clk); err_clr = 1'b1;
      nop(1);
      chk_err("erange_cleared", 1'b0);
      wr(BASE - 4, 32'h1234_5678, 4'hF);
      err_clr = 1'b1;
      nop(1);
      chk_err("erange_set_beats_clr", 1'b1);
      @(negedge clk); err_clr = 1'b1;
      nop(1);
      chk_err("erange_cleared2", 1'b0);

      // top of address space must not wrap into the array
      rd(32'hFFFF_FFFC, ERRD, 3'b111);
      nop(1);
      chk_err("erange_top", 1'b1);
      nop(5);
      @(negedge clk); err_clr = 1'b1;
      nop(1);

      // reset with reads in flight; write at the reset edge is dropped
      rd(BASE, mdl[0], 3'b001);
      @(negedge clk);
      rst = 1'b1; addr_en = 1'b1; w_nrr = 1'b0; addr = BASE + 4;
      @(negedge clk);
      w_nrr = 1'b1; addr = BASE + 4; wdata = 32'h5555_5555; wstrb = 4'hF;
      @(negedge clk);
      rst = 1'b0; addr_en = 1'b0; w_nrr = 1'b0; wstrb = '0;
      nop(6);
      for (int k = 0; k < 3; k++)
         chk($sformatf("L%0d idle_after_rst", LAT[k]), 32'(id_a[k]), 32'd1);
      chk_err("erange_after_rst", 1'b0);
      rd(BASE, mdl[0], 3'b111);
      rd(BASE + 4, mdl[1], 3'b111);
      nop(8);

      for (int k = 0; k < 3; k++) begin
         chk($sformatf("L%0d queue_drained", LAT[k]), 32'(q[k].size()), 32'd0);
         chk($sformatf("L%0d eovf_end", LAT[k]), 32'(eo_a[k]), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/ls_io_responder.md
Name: ls_io_responder

Overview:
- Slave-side responder for the load/store unit's simple memory/IO port (addr_en, s_axi_addr, s_axi_wdata, w_nrr, wstrb, s_axi_rdata, s_axi_rvalid).
- Holds a word-addressed local data array with byte-strobe writes.
- Returns full 32-bit read words, in order, after a fixed, parameterised latency. Byte/halfword alignment and sign extension stay in the load/store unit.
- Provides a sticky error status for out-of-range accesses and in-flight overflow, so the port can be verified standalone and reused as the IO sub-unit target.

Parameters:
- BASE_ADDR, 32'h6000_0000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of 2, at least 2.
- READ_LATENCY, 1, cycles from the read request edge to s_axi_rvalid; range 1..4.
- ERR_DATA, 32'hDEAD_BEEF, data returned for an out-of-range read.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- addr_en  in  1  request strobe; one request per asserted cycle, never back-pressured
- s_axi_addr  in  32  byte address; bits [1:0] ignored
- s_axi_wdata  in  32  write data, lane-aligned
- w_nrr  in  1  1 = write, 0 = read
- wstrb  in  4  byte enables; used only when writing
- s_axi_rdata  out  32  read data, valid only while s_axi_rvalid
- s_axi_rvalid  out  1  single-cycle read-return pulse
- err_range  out  1  sticky: an access fell outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)
- err_overflow  out  1  sticky: a read was accepted while READ_LATENCY reads were already in flight
- err_clr  in  1  clears both sticky flags; a new error in the same cycle wins
- idle  out  1  no reads in flight

Behaviour:
- Clock, reset and timing:
  - Single clock. Reset is synchronous and active-high.
  - On reset: s_axi_rvalid=0, s_axi_rdata=0, err_range=0, err_overflow=0, idle=1, and the read pipeline is flushed.
  - Array contents are NOT reset.
- Address decode:
  - in_range = (addr >= BASE_ADDR) and (addr < BASE_ADDR + 4*DEPTH_WORDS), computed in 33-bit arithmetic so there is no wrap at 32'hFFFF_FFFC.
  - index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
- Write (addr_en & w_nrr):
  - If in range, byte lane i of word[index] is updated at this edge only if wstrb[i] is set. wstrb=0 is a legal no-op.
  - If out of range, no array change and err_range is set.
  - Writes never produce rvalid.
- Read (addr_en & ~w_nrr):
  - The array is sampled at the request edge; any write from a prior cycle is visible.
  - The read enters a READ_LATENCY-stage shift pipeline carrying {valid, data}. Data is ERR_DATA if out of range, and err_range is also set.
  - Output: s_axi_rvalid asserts exactly READ_LATENCY cycles after the request edge, with s_axi_rdata registered.
  - Back-to-back reads produce back-to-back rvalid pulses, in order. Throughput is 1 per cycle.
  - When rvalid=0, s_axi_rdata holds its last value; the bench must not check it then.
- In-flight tracking:
  - In-flight counter width is clog2(READ_LATENCY+1).
  - It increments on an accepted read and decrements on rvalid; simultaneous increment and decrement leaves it unchanged.
  - By construction the counter is at most READ_LATENCY. err_overflow fires only if the counter would exceed that, which is a safety check.
  - idle = (count==0).
- Reset mid-operation: in-flight reads are dropped with no rvalid. A write at the reset edge is ignored.
- err_clr priority: a sticky flag follows set | (flag & ~err_clr); a same-cycle error beats the clear.
- Data ordering: a write and a read cannot coincide, since there is one request per cycle. A read in cycle N+1 after a write in cycle N returns the new data.

Decomposition:
- The package carries ls_req_t {addr, wdata, w_nrr, wstrb} and the default ERR_DATA constant. BASE_ADDR defaults come from the existing address-range constants (the IO/bus range) in the configuration package.
- One sub-module: byte_en_ram (DEPTH_WORDS x 32, per-byte write enable, synchronous read). The latency pipeline and error logic stay in ls_io_responder.

Test Plan:
- Reset then idle → rvalid=0, err_range=0, err_overflow=0, idle=1 for 10 cycles.
- Write 32'h1122_3344 at BASE_ADDR+8 with wstrb=4'hF; next cycle write 32'hAA00_0000 with wstrb=4'b1000; then read BASE_ADDR+8 → after READ_LATENCY cycles, rvalid=1 and rdata=32'hAA22_3344.
- Four back-to-back reads of words 0..3 preloaded with 0,1,2,3, at READ_LATENCY=3 → rvalid pulses in 4 consecutive cycles starting 3 cycles after the first request, rdata 0,1,2,3 in order, idle=0 throughout.
- Read at BASE_ADDR+4*DEPTH_WORDS → rdata=32'hDEAD_BEEF with rvalid, err_range=1 stays set; err_clr pulse → 0; err_clr coinciding with a new bad write → err_range stays 1.
- Read at 32'hFFFF_FFFC with default BASE_ADDR → out of range, no wrap to an in-range index.
- Issue 2 reads at READ_LATENCY=2, assert rst on the next edge → no rvalid ever appears, idle=1; array contents are unchanged on a later read.
